// File: rtl/conv1d_ctrl.sv
// conv1d_ctrl: sequencing controller for the conv1d core datapath.
//
// Produces valid-only 1-D convolution control for a single shared MAC.
// For a job of sig_len samples it loads N_TAPS weights and fills the
// sample shift chain. It then runs one MAC burst of N_TAPS cycles per
// output, presents each result on y_valid/y_ready, and slides one new
// sample in before each further output.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, sig_len      job request (sampled in IDLE) and its sample count
//   w_valid/w_ready     weight word handshake; w_load one-hot register load
//   x_valid/x_ready     sample handshake; shift_en loads the shift chain
//   mac_clr/mac_en      accumulator clear-on-load / update enable
//   tap_sel             tap addressed in the current MAC cycle
//   y_valid/y_ready     finished output handshake
//   busy, done          job in progress / one-cycle end-of-job pulse
module conv1d_ctrl #(
  parameter int N_TAPS = 3,
  parameter int TAP_W  = 2,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  sig_len,
  input  logic              w_valid,
  output logic              w_ready,
  output logic [N_TAPS-1:0] w_load,
  input  logic              x_valid,
  output logic              x_ready,
  output logic              shift_en,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [TAP_W-1:0]  tap_sel,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_FILL   = 3'd2,
    S_MAC    = 3'd3,
    S_OUT    = 3'd4,
    S_SLIDE  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [TAP_W-1:0]  LAST_TAP = TAP_W'(N_TAPS - 1);
  localparam logic [TAP_W-1:0]  TAP_ZERO = TAP_W'(0);
  localparam logic [TAP_W-1:0]  TAP_ONE  = TAP_W'(1);
  localparam logic [LEN_W-1:0]  LEN_TAPS = LEN_W'(N_TAPS);
  localparam logic [LEN_W-1:0]  LEN_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [N_TAPS-1:0] LOAD_LSB = N_TAPS'(1);

  state_t             state_q, state_d;
  // Shared counter: weight index in LOAD_W, sample index in FILL, tap in MAC.
  logic [TAP_W-1:0]   tap_cnt_q, tap_cnt_d;
  logic [LEN_W-1:0]   out_cnt_q, out_cnt_d;
  logic [LEN_W-1:0]   n_out_q, n_out_d;

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tap_cnt_q <= TAP_ZERO;
      out_cnt_q <= LEN_ZERO;
      n_out_q   <= LEN_ZERO;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      out_cnt_q <= out_cnt_d;
      n_out_q   <= n_out_d;
    end
  end

  // Next-state, counter update and output decode.
  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    out_cnt_d = out_cnt_q;
    n_out_d   = n_out_q;
    w_ready   = 1'b0;
    w_load    = '0;
    x_ready   = 1'b0;
    shift_en  = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    tap_sel   = TAP_ZERO;
    y_valid   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        tap_cnt_d = TAP_ZERO;
        out_cnt_d = LEN_ZERO;
        if (start) begin
          // Jobs too short for even one output finish without handshakes.
          if (sig_len >= LEN_TAPS) begin
            n_out_d = sig_len - LEN_TAPS + LEN_ONE;
            state_d = S_LOAD_W;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          w_load = LOAD_LSB << tap_cnt_q;
          if (tap_cnt_q == LAST_TAP) begin
            tap_cnt_d = TAP_ZERO;
            state_d   = S_FILL;
          end else begin
            tap_cnt_d = tap_cnt_q + TAP_ONE;
          end
        end else begin
          w_load = '0;
        end
      end

      S_FILL: begin
        x_ready = 1'b1;
        if (x_valid) begin
          shift_en = 1'b1;
          if (tap_cnt_q == LAST_TAP) begin
            tap_cnt_d = TAP_ZERO;
            state_d   = S_MAC;
          end else begin
            tap_cnt_d = tap_cnt_q + TAP_ONE;
          end
        end else begin
          shift_en = 1'b0;
        end
      end

      S_MAC: begin
        mac_en  = 1'b1;
        tap_sel = tap_cnt_q;
        mac_clr = (tap_cnt_q == TAP_ZERO);
        if (tap_cnt_q == LAST_TAP) begin
          tap_cnt_d = TAP_ZERO;
          state_d   = S_OUT;
        end else begin
          tap_cnt_d = tap_cnt_q + TAP_ONE;
        end
      end

      S_OUT: begin
        y_valid = 1'b1;
        if (y_ready) begin
          out_cnt_d = out_cnt_q + LEN_ONE;
          if (out_cnt_q == (n_out_q - LEN_ONE)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SLIDE;
          end
        end else begin
          state_d = S_OUT;
        end
      end

      S_SLIDE: begin
        x_ready = 1'b1;
        if (x_valid) begin
          shift_en = 1'b1;
          state_d  = S_MAC;
        end else begin
          shift_en = 1'b0;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_conv1d_ctrl.sv
// Self-checking bench for conv1d_ctrl (N_TAPS=3). Every control event the
// controller produces (weight load, shift, MAC cycle, y handshake, done) is
// turned into a token at the falling edge and compared in order against the
// tokens each scenario pushes when it starts a job.
module tb_conv1d_ctrl;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] sig_len = 8'd0;
  logic       w_valid = 1'b0;
  logic       w_ready;
  logic [2:0] w_load;
  logic       x_valid = 1'b0;
  logic       x_ready;
  logic       shift_en;
  logic       mac_clr;
  logic       mac_en;
  logic [1:0] tap_sel;
  logic       y_valid;
  logic       y_ready = 1'b0;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs[$];
  logic [7:0] e;

  int busy_cnt, done_cnt, wr_cnt, xr_cnt, yv_cnt, first_mac;

  conv1d_ctrl #(.N_TAPS(3), .TAP_W(2), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sig_len(sig_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_load(w_load),
    .x_valid(x_valid), .x_ready(x_ready), .shift_en(shift_en),
    .mac_clr(mac_clr), .mac_en(mac_en), .tap_sel(tap_sel),
    .y_valid(y_valid), .y_ready(y_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: tokenise events and compare against the scoreboard.
  always @(negedge clk) begin
    obs.delete();
    if (w_load != 3'b000) obs.push_back({5'b00010, w_load});
    if (shift_en) obs.push_back(8'h20);
    if (mac_en) obs.push_back({5'b00110, mac_clr, tap_sel});
    if (y_valid && y_ready) obs.push_back(8'h40);
    if (done) obs.push_back(8'h50);
    foreach (obs[i]) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra got=%h expected=none (cycle %0d)", obs[i], cyc);
      end else begin
        e = exp_q.pop_front();
        if (obs[i] !== e) begin
          bad++;
          $display("FAIL sb_token got=%h expected=%h (cycle %0d)", obs[i], e, cyc);
        end
      end
    end
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (w_ready) wr_cnt++;
    if (x_ready) xr_cnt++;
    if (y_valid) yv_cnt++;
    if (mac_en && first_mac < 0) first_mac = cyc;
  end

  task automatic clr_mon();
    busy_cnt = 0; done_cnt = 0; wr_cnt = 0; xr_cnt = 0; yv_cnt = 0;
    first_mac = -1;
  endtask

  // Expected event sequence of one job, derived from the job length.
  task automatic push_job(input int len);
    int n;
    if (len < N) begin
      exp_q.push_back(8'h50);
    end else begin
      n = len - N + 1;
      for (int k = 0; k < N; k++) exp_q.push_back(8'h10 | (8'd1 << k));
      for (int k = 0; k < N; k++) exp_q.push_back(8'h20);
      for (int j = 0; j < n; j++) begin
        if (j > 0) exp_q.push_back(8'h20);
        for (int k = 0; k < N; k++)
          exp_q.push_back(8'h30 | ((k == 0) ? 8'h04 : 8'h00) | 8'(k));
        exp_q.push_back(8'h40);
      end
      exp_q.push_back(8'h50);
    end
  endtask

  function automatic int done_off(input int len);
    int n;
    if (len < N) return 1;
    n = len - N + 1;
    return 2 * N + n * (N + 1) + (n - 1) + 1;
  endfunction

  task automatic wait_done(output int d, output bit ok);
    int i;
    ok = 1'b0; d = -1; i = 0;
    while (!ok && i < 300) begin
      @(posedge clk); #1;
      if (done) begin ok = 1'b1; d = cyc; end
      i++;
    end
  endtask

  task automatic test_reset();
    start = 1'b1; w_valid = 1'b1; x_valid = 1'b1; y_ready = 1'b1; sig_len = 8'd5;
    @(negedge clk);
    total++;
    if ({w_ready, w_load, x_ready, shift_en, mac_clr, mac_en, tap_sel, y_valid, busy, done} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b expected=0", {w_ready, w_load, x_ready, shift_en, mac_clr, mac_en, tap_sel, y_valid, busy, done});
    end
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy=%b expected=0", busy); end
  endtask

  task automatic test_basic();
    int c, d; bit ok;
    w_valid = 1'b1; x_valid = 1'b1; y_ready = 1'b1;
    clr_mon(); push_job(5);
    start = 1'b1; sig_len = 8'd5; c = cyc;
    @(posedge clk); #1; start = 1'b0;
    wait_done(d, ok);
    @(posedge clk); #1;
    total++;
    if (!ok || d - c != done_off(5)) begin bad++; $display("FAIL basic_latency got=%0d expected=%0d", d - c, done_off(5)); end
    total++;
    if (busy_cnt != done_off(5)) begin bad++; $display("FAIL basic_busy got=%0d expected=%0d", busy_cnt, done_off(5)); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d expected=1", done_cnt); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL basic_leftover got=%0d expected=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_short();
    int lens[3] = '{3, 2, 0};
    int c, d; bit ok;
    w_valid = 1'b1; x_valid = 1'b1; y_ready = 1'b1;
    foreach (lens[i]) begin
      clr_mon(); push_job(lens[i]);
      start = 1'b1; sig_len = 8'(lens[i]); c = cyc;
      @(posedge clk); #1; start = 1'b0;
      if (done) begin d = cyc; ok = 1'b1; end else wait_done(d, ok);
      @(posedge clk); #1;
      total++;
      if (!ok || d - c != done_off(lens[i])) begin bad++; $display("FAIL short_latency len=%0d got=%0d expected=%0d", lens[i], d - c, done_off(lens[i])); end
      total++;
      if (lens[i] < N) begin
        if (wr_cnt + xr_cnt + yv_cnt != 0) begin bad++; $display("FAIL short_no_hs len=%0d got=%0d expected=0", lens[i], wr_cnt + xr_cnt + yv_cnt); end
      end else begin
        if (yv_cnt != 1) begin bad++; $display("FAIL short_one_y len=%0d got=%0d expected=1", lens[i], yv_cnt); end
      end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL short_leftover len=%0d got=%0d expected=0", lens[i], exp_q.size()); exp_q.delete(); end
    end
  endtask

  task automatic test_backpressure();
    int c, d, i; bit ok, seen;
    w_valid = 1'b1; x_valid = 1'b1; y_ready = 1'b0;
    clr_mon(); push_job(5);
    start = 1'b1; sig_len = 8'd5; c = cyc;
    @(posedge clk); #1; start = 1'b0;
    seen = 1'b0; i = 0;
    while (!seen && i < 100) begin
      @(posedge clk); #1;
      if (y_valid) seen = 1'b1;
      i++;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL bp_wait_y got=timeout expected=y_valid"); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({y_valid, x_ready, shift_en, mac_en} !== 4'b1000) begin
        bad++; $display("FAIL bp_stall k=%0d got=%b expected=1000", k, {y_valid, x_ready, shift_en, mac_en});
      end
      @(posedge clk); #1;
    end
    y_ready = 1'b1;
    wait_done(d, ok);
    @(posedge clk); #1;
    total++;
    if (!ok || d - c != done_off(5) + 5) begin bad++; $display("FAIL bp_latency got=%0d expected=%0d", d - c, done_off(5) + 5); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL bp_leftover got=%0d expected=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_gaps();
    int pat[5] = '{1, 0, 0, 1, 1};
    int c, d; bit ok;
    w_valid = 1'b0; x_valid = 1'b1; y_ready = 1'b1;
    clr_mon(); push_job(5);
    start = 1'b1; sig_len = 8'd5; c = cyc;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; start = 1'b0;
      w_valid = pat[i][0]; x_valid = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      w_valid = 1'b1; x_valid = pat[i][0];
    end
    @(posedge clk); #1; x_valid = 1'b1;
    wait_done(d, ok);
    @(posedge clk); #1;
    total++;
    if (first_mac - c != 11) begin bad++; $display("FAIL gaps_mac_start got=%0d expected=11", first_mac - c); end
    total++;
    if (!ok || d - c != done_off(5) + 4) begin bad++; $display("FAIL gaps_latency got=%0d expected=%0d", d - c, done_off(5) + 4); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL gaps_leftover got=%0d expected=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid();
    int c, d, i; bit ok, seen;
    w_valid = 1'b1; x_valid = 1'b1; y_ready = 1'b1;
    clr_mon();
    for (int k = 0; k < N; k++) exp_q.push_back(8'h10 | (8'd1 << k));
    for (int k = 0; k < N; k++) exp_q.push_back(8'h20);
    exp_q.push_back(8'h34);
    start = 1'b1; sig_len = 8'd5;
    @(posedge clk); #1; start = 1'b0;
    seen = 1'b0; i = 0;
    while (!seen && i < 100) begin
      @(posedge clk); #1;
      if (mac_en) seen = 1'b1;
      i++;
    end
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    total++;
    if (!seen || {w_ready, w_load, x_ready, shift_en, mac_clr, mac_en, tap_sel, y_valid, busy, done} !== 13'd0) begin
      bad++;
      $display("FAIL midreset_outputs got=%b expected=0", {w_ready, w_load, x_ready, shift_en, mac_clr, mac_en, tap_sel, y_valid, busy, done});
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (done_cnt != 0 || busy !== 1'b0) begin bad++; $display("FAIL midreset_no_done done=%0d busy=%b expected=0,0", done_cnt, busy); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL midreset_leftover got=%0d expected=0", exp_q.size()); exp_q.delete(); end
    clr_mon(); push_job(4);
    start = 1'b1; sig_len = 8'd4; c = cyc;
    @(posedge clk); #1; start = 1'b0;
    wait_done(d, ok);
    @(posedge clk); #1;
    total++;
    if (!ok || d - c != done_off(4) || yv_cnt != 2) begin bad++; $display("FAIL midreset_rerun lat=%0d y=%0d expected=%0d,2", d - c, yv_cnt, done_off(4)); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rerun_leftover got=%0d expected=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    int c, d1, d2; bit ok;
    w_valid = 1'b1; x_valid = 1'b1; y_ready = 1'b1;
    clr_mon(); push_job(3); push_job(4);
    start = 1'b1; sig_len = 8'd3; c = cyc;
    @(posedge clk); #1; sig_len = 8'd4;
    wait_done(d1, ok);
    total++;
    if (!ok || d1 - c != done_off(3)) begin bad++; $display("FAIL b2b_first got=%0d expected=%0d", d1 - c, done_off(3)); end
    @(posedge clk); #1;
    total++;
    if ({busy, w_ready} !== 2'b00) begin bad++; $display("FAIL b2b_idle got=%b expected=00", {busy, w_ready}); end
    @(posedge clk); #1;
    total++;
    if (w_ready !== 1'b1) begin bad++; $display("FAIL b2b_restart w_ready=%b expected=1", w_ready); end
    start = 1'b0;
    wait_done(d2, ok);
    @(posedge clk); #1;
    total++;
    if (!ok || d2 - d1 != 1 + done_off(4)) begin bad++; $display("FAIL b2b_second got=%0d expected=%0d", d2 - d1, 1 + done_off(4)); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_leftover got=%0d expected=0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_basic();
    test_short();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv1d_ctrl.md
Name: conv1d_ctrl

Overview:
Sequencing controller for the conv1d core datapath. It drives the load enables of the weight registers and the sample shift chain, and the clear/accumulate/tap-select controls of a single shared MAC. Valid-only (no padding) convolution: for sig_len input samples it produces sig_len-N_TAPS+1 outputs. Upstream and downstream connect through valid/ready handshakes.

Parameters:
N_TAPS, 3, kernel length; number of weight registers and sample shift-chain stages (>=2)
TAP_W, 2, width of tap_sel; must satisfy 2**TAP_W >= N_TAPS
LEN_W, 8, width of sig_len and the internal sample/output counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a convolution job; sampled only in IDLE
sig_len  in  LEN_W  number of input samples in the job; captured when start is accepted
w_valid  in  1  weight word available upstream
w_ready  out  1  controller accepts a weight word
w_load  out  N_TAPS  one-hot load enable for weight register k
x_valid  in  1  input sample available upstream
x_ready  out  1  controller accepts an input sample
shift_en  out  1  load enable of the sample shift chain
mac_clr  out  1  accumulator loads the product instead of adding it
mac_en  out  1  MAC update enable
tap_sel  out  TAP_W  weight/sample tap selected for the current MAC cycle
y_valid  out  1  accumulator holds a finished output
y_ready  in  1  downstream accepts the output
busy  out  1  job in progress (any state other than IDLE)
done  out  1  single-cycle pulse at the end of a job

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; all counters 0; every output 0. Reset mid-job aborts the job without a done pulse. Datapath register contents are not this block's concern.
- All outputs are decoded from state and counters only. No input-to-output combinational path except w_load and shift_en, which are gated by w_valid and x_valid in the same cycle.
- Handshake: a transfer occurs on a rising edge where valid&ready=1. w_load[k] and shift_en are asserted in that same cycle.
- n_out = sig_len-N_TAPS+1, computed at start. Unsigned LEN_W arithmetic.
- IDLE: busy=0. start=1 with sig_len>=N_TAPS goes to LOAD_W. start=1 with sig_len<N_TAPS (including 0) goes to DONE, with no handshakes and no y_valid. start is ignored in every other state.
- LOAD_W: w_ready=1. The k-th accepted weight (k=0..N_TAPS-1) asserts w_load=1<<k. After the N_TAPS-th accept, go to FILL.
- FILL: x_ready=1. Each accept asserts shift_en. After N_TAPS accepts, go to MAC.
- MAC: runs exactly N_TAPS cycles with mac_en=1 and tap_sel=0,1,...,N_TAPS-1. mac_clr=1 only on the tap_sel=0 cycle. Then go to OUT.
- OUT: y_valid=1, held stable until y_ready=1; nothing else changes while stalled. On the handshake out_cnt increments. If it was output n_out-1, go to DONE; otherwise go to SLIDE.
- SLIDE: x_ready=1. One accept asserts shift_en and goes to MAC.
- DONE: done=1 and busy=1 for one cycle, then IDLE. busy=0 in IDLE, so a new start can be accepted the cycle after done.
- Latency: if the last FILL/SLIDE accept is at edge t, MAC occupies cycles t+1..t+N_TAPS and y_valid rises in cycle t+N_TAPS+1. Throughput is at best one output per N_TAPS+2 cycles.
- Counts per job: exactly N_TAPS w_load pulses, sig_len shift_en pulses, N_TAPS*n_out mac_en cycles, and n_out y handshakes.
- x_valid/w_valid outside their accepting states are ignored, and never cause w_load or shift_en.
- y_ready outside OUT is ignored.
- sig_len changes after start have no effect.

Test Plan:
1. N_TAPS=3, sig_len=5, all valids and y_ready tied 1, start pulse -> w_load sequence 001,010,100; shift_en 5 pulses; 3 y handshakes; 9 mac_en cycles with tap_sel 0,1,2 repeating and mac_clr on each tap_sel=0; done single pulse; busy high from the cycle after start through the done cycle.
2. sig_len=3 -> one MAC burst, exactly one y_valid handshake, then done. sig_len=2 and sig_len=0 -> done pulse one cycle after start; w_ready, x_ready and y_valid never asserted.
3. Backpressure: y_ready=0 for 5 cycles during the first OUT -> y_valid stays 1, x_ready=0, and shift_en/mac_en stay 0 throughout; completion is delayed exactly 5 cycles versus scenario 1.
4. Upstream gaps: x_valid toggles 1,0,0,1,1 during FILL, and w_valid has a 2-cycle gap -> w_load and shift_en fire only on handshake cycles; MAC starts the cycle after the 3rd sample accept.
5. Reset pulse in the 2nd MAC cycle -> all outputs 0 asynchronously, state IDLE, no done pulse; a following job with sig_len=4 completes with 2 outputs.
6. start held high throughout a job, plus a second start right after done -> the mid-job start is ignored; the second job begins in the cycle after done.
